// File: rtl/cdb_arbiter.sv
// cdb_arbiter: transmitter end of the common data bus.
// Each execution unit (int=0, ls=1, mult=2, div=3) owns one holding slot.
// Full slots are arbitrated (round-robin or fixed priority) and at most one
// result per cycle is broadcast on a registered CDB.
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   <u>_valid/_tag/_data     result presented by unit <u>
//   <u>_ready                slot can take a result on this edge
//   int_branch/int_taken     branch resolution info (int unit only)
//   cdb_valid/tag/data       broadcast result
//   cdb_branch/cdb_taken     broadcast is a resolved branch / its outcome
module cdb_arbiter #(
    parameter int W_DATA = 32,
    parameter int W_TAG  = 6,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_valid,
    output logic              int_ready,
    input  logic [W_TAG-1:0]  int_tag,
    input  logic [W_DATA-1:0] int_data,
    input  logic              int_branch,
    input  logic              int_taken,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic [W_TAG-1:0]  ls_tag,
    input  logic [W_DATA-1:0] ls_data,
    input  logic              mult_valid,
    output logic              mult_ready,
    input  logic [W_TAG-1:0]  mult_tag,
    input  logic [W_DATA-1:0] mult_data,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [W_TAG-1:0]  div_tag,
    input  logic [W_DATA-1:0] div_data,
    output logic              cdb_valid,
    output logic [W_TAG-1:0]  cdb_tag,
    output logic [W_DATA-1:0] cdb_data,
    output logic              cdb_branch,
    output logic              cdb_taken
);
    localparam int NUM_SRC = 4;

    logic [NUM_SRC-1:0]             in_vld;
    logic [NUM_SRC-1:0][W_TAG-1:0]  in_tag;
    logic [NUM_SRC-1:0][W_DATA-1:0] in_data;
    logic [NUM_SRC-1:0]             rdy;
    logic [NUM_SRC-1:0]             acc;

    logic [NUM_SRC-1:0]             full_q;
    logic [NUM_SRC-1:0][W_TAG-1:0]  tag_q;
    logic [NUM_SRC-1:0][W_DATA-1:0] data_q;
    logic                           br_q, tk_q;
    logic [1:0]                     rr_q;

    logic                           gnt_vld;
    logic [1:0]                     gnt_idx;

    assign in_vld  = {div_valid, mult_valid, ls_valid, int_valid};
    assign in_tag  = {div_tag, mult_tag, ls_tag, int_tag};
    assign in_data = {div_data, mult_data, ls_data, int_data};

    // First full slot in search order; search starts at rr_q when
    // round-robin is enabled, otherwise at int. Depends on slot state only.
    always_comb begin
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = RR_EN ? rr_q + 2'(k) : 2'(k);
            if (!gnt_vld && full_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // A slot being granted this cycle frees up on the same edge, so it can
    // accept again; no path from valid to ready.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
        assign rdy[i] = ~full_q[i] | (gnt_vld && gnt_idx == 2'(i));
        assign acc[i] = in_vld[i] & rdy[i];
    end

    assign int_ready  = rdy[0];
    assign ls_ready   = rdy[1];
    assign mult_ready = rdy[2];
    assign div_ready  = rdy[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q     <= '0;
            tag_q      <= '0;
            data_q     <= '0;
            br_q       <= 1'b0;
            tk_q       <= 1'b0;
            rr_q       <= 2'd0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_branch <= 1'b0;
            cdb_taken  <= 1'b0;
        end else begin
            // Refill takes precedence over the grant clearing the slot.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (acc[i]) begin
                    full_q[i] <= 1'b1;
                    tag_q[i]  <= in_tag[i];
                    data_q[i] <= in_data[i];
                end else if (gnt_vld && gnt_idx == 2'(i)) begin
                    full_q[i] <= 1'b0;
                end
            end
            if (acc[0]) begin
                br_q <= int_branch;
                tk_q <= int_taken;
            end
            if (gnt_vld) begin
                cdb_valid  <= 1'b1;
                cdb_tag    <= tag_q[gnt_idx];
                cdb_data   <= data_q[gnt_idx];
                cdb_branch <= (gnt_idx == 2'd0) & br_q;
                cdb_taken  <= (gnt_idx == 2'd0) & br_q & tk_q;
                rr_q       <= gnt_idx + 2'd1;
            end else begin
                // tag/data keep their last broadcast value
                cdb_valid  <= 1'b0;
                cdb_branch <= 1'b0;
                cdb_taken  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: two instances, d=0 round-robin, d=1 fixed priority.
// A per-cycle reference model of the slots and bus checks ready and every
// CDB field; a data scoreboard checks nothing is lost or duplicated.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        v   [2][4];
    logic [5:0]  tg  [2][4];
    logic [31:0] dt  [2][4];
    logic        br  [2];
    logic        tk  [2];
    logic        rdy [2][4];
    logic        cv  [2];
    logic [5:0]  ct  [2];
    logic [31:0] cd  [2];
    logic        cb  [2];
    logic        ck  [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        cdb_arbiter #(.W_DATA(32), .W_TAG(6), .RR_EN(d == 0)) u_dut (
            .clk(clk), .reset(reset),
            .int_valid(v[d][0]), .int_ready(rdy[d][0]), .int_tag(tg[d][0]), .int_data(dt[d][0]),
            .int_branch(br[d]), .int_taken(tk[d]),
            .ls_valid(v[d][1]), .ls_ready(rdy[d][1]), .ls_tag(tg[d][1]), .ls_data(dt[d][1]),
            .mult_valid(v[d][2]), .mult_ready(rdy[d][2]), .mult_tag(tg[d][2]), .mult_data(dt[d][2]),
            .div_valid(v[d][3]), .div_ready(rdy[d][3]), .div_tag(tg[d][3]), .div_data(dt[d][3]),
            .cdb_valid(cv[d]), .cdb_tag(ct[d]), .cdb_data(cd[d]),
            .cdb_branch(cb[d]), .cdb_taken(ck[d])
        );
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_full [2][4];
    logic [5:0]  m_tag  [2][4];
    logic [31:0] m_data [2][4];
    bit          m_br [2], m_tk [2];
    int          m_rr [2];
    bit          e_cv [2], e_cb [2], e_ck [2];
    logic [5:0]  e_ct [2];
    logic [31:0] e_cd [2];
    bit          acc  [2][4];
    logic [31:0] sb   [2][$];
    int          ser = 0;

    function automatic int m_grant(int d);
        for (int k = 0; k < 4; k++) begin
            int idx = (d == 0) ? (m_rr[d] + k) % 4 : k;
            if (m_full[d][idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                m_full[d][i] = 0; m_tag[d][i] = '0; m_data[d][i] = '0; acc[d][i] = 0;
                v[d][i] = 0; tg[d][i] = '0; dt[d][i] = '0;
            end
            m_br[d] = 0; m_tk[d] = 0; m_rr[d] = 0; br[d] = 0; tk[d] = 0;
            e_cv[d] = 0; e_cb[d] = 0; e_ck[d] = 0; e_ct[d] = '0; e_cd[d] = '0;
            sb[d].delete();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_clear();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_cv", cv[d], 0); chk("rst_ct", ct[d], 0); chk("rst_cd", cd[d], 0);
            chk("rst_cb", cb[d], 0); chk("rst_ck", ck[d], 0);
        end
        repeat (n) @(posedge clk);
        #1 reset = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) chk("rst_rdy", rdy[d][i], 1);
    endtask

    // One clock: check readies, take the edge, advance the model, check bus.
    task automatic cycle();
        int g [2];
        for (int d = 0; d < 2; d++) begin
            g[d] = m_grant(d);
            for (int i = 0; i < 4; i++) begin
                bit er = !m_full[d][i] || g[d] == i;
                chk($sformatf("ready%0d_%0d", d, i), rdy[d][i], er);
                acc[d][i] = v[d][i] && er;
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (g[d] >= 0) begin
                e_cv[d] = 1; e_ct[d] = m_tag[d][g[d]]; e_cd[d] = m_data[d][g[d]];
                e_cb[d] = g[d] == 0 && m_br[d];
                e_ck[d] = g[d] == 0 && m_br[d] && m_tk[d];
                m_full[d][g[d]] = 0;
                m_rr[d] = (g[d] + 1) % 4;
            end else begin
                e_cv[d] = 0; e_cb[d] = 0; e_ck[d] = 0;
            end
            for (int i = 0; i < 4; i++) if (acc[d][i]) begin
                m_full[d][i] = 1; m_tag[d][i] = tg[d][i]; m_data[d][i] = dt[d][i];
                if (i == 0) begin m_br[d] = br[d]; m_tk[d] = tk[d]; end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cdb_valid%0d", d), cv[d], e_cv[d]);
            chk($sformatf("cdb_tag%0d", d), ct[d], e_ct[d]);
            chk($sformatf("cdb_data%0d", d), cd[d], e_cd[d]);
            chk($sformatf("cdb_branch%0d", d), cb[d], e_cb[d]);
            chk($sformatf("cdb_taken%0d", d), ck[d], e_ck[d]);
            if (cv[d]) begin
                int hit = -1;
                foreach (sb[d][j]) if (hit < 0 && sb[d][j] == cd[d]) hit = j;
                chk($sformatf("sb_hit%0d", d), hit >= 0, 1);
                if (hit >= 0) sb[d].delete(hit);
            end
            for (int i = 0; i < 4; i++) if (acc[d][i]) sb[d].push_back(dt[d][i]);
        end
    endtask

    // Unit driver: holds valid and payload until accepted, then maybe offers a new one.
    task automatic drive_rand(input int d, input int i, input int pct);
        if (v[d][i] && !acc[d][i]) return;
        if (int'($urandom_range(99)) < pct) begin
            ser++;
            v[d][i] = 1; tg[d][i] = ser[5:0]; dt[d][i] = {2'(i), ser[29:0]};
            if (i == 0) begin br[d] = 1'($urandom); tk[d] = 1'($urandom); end
        end else begin
            v[d][i] = 0;
            if (i == 0) begin br[d] = 0; tk[d] = 0; end
        end
    endtask

    task automatic idle(input int n);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) v[d][i] = 0;
            br[d] = 0; tk[d] = 0;
        end
        repeat (n) cycle();
    endtask

    initial begin
        int nacc, cyc, mwait;
        bit mpend;
        logic [31:0] mdat;

        // Reset and idle
        do_reset(3);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("idle_cv", cv[0], 0);
        end

        // Single int branch
        v[0][0] = 1; tg[0][0] = 6'h05; dt[0][0] = 32'h0000_1234; br[0] = 1; tk[0] = 1;
        cycle();
        v[0][0] = 0; br[0] = 0; tk[0] = 0;
        cycle();
        chk("br_cv", cv[0], 1); chk("br_tag", ct[0], 6'h05); chk("br_data", cd[0], 32'h1234);
        chk("br_branch", cb[0], 1); chk("br_taken", ck[0], 1);
        cycle();
        chk("br_cv_off", cv[0], 0); chk("br_branch_off", cb[0], 0);

        // All four simultaneous from rr_ptr=0
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            v[0][i] = 1; tg[0][i] = 6'(i + 1); dt[0][i] = 32'hA0 + i;
        end
        cycle();
        idle(0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("all4_tag", ct[0], k + 1);
            chk("all4_branch", cb[0], 0);
        end
        idle(2);

        // Backpressure: int/ls stream, mult always valid, div random; d1 random
        nacc = 0; cyc = 0; mpend = 0; mwait = 0; mdat = '0;
        while (nacc < 200 && cyc < 3000) begin
            cyc++;
            drive_rand(0, 0, 100); drive_rand(0, 1, 100);
            drive_rand(0, 2, 100); drive_rand(0, 3, 30);
            for (int i = 0; i < 4; i++) drive_rand(1, i, 50);
            cycle();
            for (int i = 0; i < 4; i++) if (acc[0][i]) nacc++;
            if (mpend) begin
                mwait++;
                if (cv[0] && cd[0] == mdat) begin
                    chk("mult_latency_ok", mwait <= 4, 1);
                    mpend = 0;
                end else if (mwait > 4) begin
                    chk("mult_latency", mwait, 4);
                    mpend = 0;
                end
            end
            if (acc[0][2]) begin mpend = 1; mwait = 0; mdat = dt[0][2]; end
        end
        chk("bp_budget", nacc >= 200, 1);
        idle(8);
        chk("sb_drain0", sb[0].size(), 0);
        chk("sb_drain1", sb[1].size(), 0);

        // Fixed priority on d1: int and div valid every cycle
        for (int k = 0; k < 12; k++) begin
            drive_rand(1, 0, 100); drive_rand(1, 3, 100);
            cycle();
            if (k >= 2) begin
                chk("fp_int_gnt", cd[1][31:30], 0);
                chk("fp_div_starve", rdy[1][3], 0);
            end
        end
        v[1][0] = 0; br[1] = 0; tk[1] = 0;
        cycle();
        chk("fp_last_int", cd[1][31:30], 0);
        v[1][3] = 0;
        cycle();
        chk("fp_div_cv", cv[1], 1);
        chk("fp_div_gnt", cd[1][31:30], 3);
        idle(4);

        // Reset mid-flight
        for (int i = 0; i < 4; i++) begin
            v[0][i] = 1; tg[0][i] = 6'h2A + 6'(i); dt[0][i] = 32'hDEAD_0000 + i;
        end
        cycle();
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("midrst_cv", cv[0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
